// File: rtl/window_accumulator.sv
// window_accumulator: collects WIN unsigned samples from the adder result
// stream and presents the saturated total, maximum and minimum of each window
// on a registered valid/ready output port.
module window_accumulator #(
    parameter int DATA_W = 8,
    parameter int WIN    = 8,
    parameter int SUM_W  = 16
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [SUM_W-1:0]  out_sum_o,
    output logic [DATA_W-1:0] out_max_o,
    output logic [DATA_W-1:0] out_min_o,
    output logic              out_ovf_o
);

    localparam int CNT_W = (WIN > 2) ? $clog2(WIN) : 1;

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SUM_W-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] run_max_q, run_max_d;
    logic [DATA_W-1:0] run_min_q, run_min_d;

    logic              out_valid_q, out_valid_d;
    logic [SUM_W-1:0]  out_sum_q, out_sum_d;
    logic [DATA_W-1:0] out_max_q, out_max_d;
    logic [DATA_W-1:0] out_min_q, out_min_d;
    logic              out_ovf_q, out_ovf_d;

    logic              accept;
    logic              first;
    logic              last;
    logic [SUM_W:0]    sum_ext;
    logic [SUM_W-1:0]  sum_sat;
    logic              add_ovf;
    logic [DATA_W-1:0] new_max;
    logic [DATA_W-1:0] new_min;

    // Sample datapath: saturating add plus running extremes including the
    // incoming sample. In HOLD count and acc are already zero, so the same
    // path starts the next window when the result handshake overlaps a sample.
    always_comb begin
        in_ready_o = (state_q == ST_ACC) ? !flush_i : (out_ready_i && !flush_i);
        accept     = in_valid_i && in_ready_o;
        first      = (count_q == '0);
        last       = (count_q == CNT_W'(WIN - 1));
        sum_ext    = {1'b0, acc_q} + {{(SUM_W + 1 - DATA_W){1'b0}}, in_data_i};
        add_ovf    = sum_ext[SUM_W];
        sum_sat    = add_ovf ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
        new_max    = (first || in_data_i > run_max_q) ? in_data_i : run_max_q;
        new_min    = (first || in_data_i < run_min_q) ? in_data_i : run_min_q;
    end

    // Next-state logic for the window registers, FSM and output port.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        run_max_d   = run_max_q;
        run_min_d   = run_min_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_max_d   = out_max_q;
        out_min_d   = out_min_q;
        out_ovf_d   = out_ovf_q;

        // Result handshake; flush never blocks it.
        if (state_q == ST_HOLD && out_ready_i) begin
            state_d     = ST_ACC;
            out_valid_d = 1'b0;
        end

        // Flush only discards a partial window; in HOLD nothing is partial.
        if (state_q == ST_ACC && flush_i) begin
            count_d   = '0;
            acc_d     = '0;
            ovf_d     = 1'b0;
            run_max_d = '0;
            run_min_d = '0;
        end

        if (accept) begin
            if (last) begin
                out_valid_d = 1'b1;
                out_sum_d   = sum_sat;
                out_max_d   = new_max;
                out_min_d   = new_min;
                out_ovf_d   = ovf_q || add_ovf;
                count_d     = '0;
                acc_d       = '0;
                ovf_d       = 1'b0;
                state_d     = ST_HOLD;
            end else begin
                acc_d     = sum_sat;
                ovf_d     = ovf_q || add_ovf;
                run_max_d = new_max;
                run_min_d = new_min;
                count_d   = count_q + CNT_W'(1);
            end
        end
    end

    // State and output registers; reset discards any window in progress.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= ST_ACC;
            count_q     <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            run_max_q   <= '0;
            run_min_q   <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_max_q   <= '0;
            out_min_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            run_max_q   <= run_max_d;
            run_min_q   <= run_min_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_max_q   <= out_max_d;
            out_min_q   <= out_min_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_sum_o   = out_sum_q;
    assign out_max_o   = out_max_q;
    assign out_min_o   = out_min_q;
    assign out_ovf_o   = out_ovf_q;

endmodule

// File: tb/tb_window_accumulator.sv
// Bench for window_accumulator: two instances (default SUM_W and SUM_W=10)
// share all inputs; a window-level reference model predicts every output.
module tb_window_accumulator;

    localparam int WIN = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        flush;
    logic        out_ready;

    logic        rdy0, vld0, ovf0;
    logic [15:0] sum0;
    logic [7:0]  max0, min0;
    logic        rdy1, vld1, ovf1;
    logic [9:0]  sum1;
    logic [7:0]  max1, min1;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: samples of the current window, and the result held.
    int   win_q[$];
    bit   m_hold;
    int   m_total, m_max, m_min;

    always #5 clk = ~clk;

    window_accumulator #(.DATA_W(8), .WIN(WIN), .SUM_W(16)) u_dut0 (
        .clk_i(clk), .reset_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_ready_o(rdy0), .flush_i(flush), .out_valid_o(vld0), .out_ready_i(out_ready),
        .out_sum_o(sum0), .out_max_o(max0), .out_min_o(min0), .out_ovf_o(ovf0)
    );

    window_accumulator #(.DATA_W(8), .WIN(WIN), .SUM_W(10)) u_dut1 (
        .clk_i(clk), .reset_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_ready_o(rdy1), .flush_i(flush), .out_valid_o(vld1), .out_ready_i(out_ready),
        .out_sum_o(sum1), .out_max_o(max1), .out_min_o(min1), .out_ovf_o(ovf1)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int sat(input int x, input int w);
        int lim = (1 << w) - 1;
        return (x > lim) ? lim : x;
    endfunction

    task automatic model_reset();
        win_q.delete();
        m_hold = 1'b0;
    endtask

    task automatic check_outputs();
        bit exp_rdy = !flush && (!m_hold || out_ready);
        chk("in_ready0", int'(rdy0), int'(exp_rdy));
        chk("in_ready1", int'(rdy1), int'(exp_rdy));
        chk("out_valid0", int'(vld0), int'(m_hold));
        chk("out_valid1", int'(vld1), int'(m_hold));
        if (m_hold) begin
            chk("sum0", int'(sum0), sat(m_total, 16));
            chk("ovf0", int'(ovf0), int'(m_total > 65535));
            chk("sum1", int'(sum1), sat(m_total, 10));
            chk("ovf1", int'(ovf1), int'(m_total > 1023));
            chk("max0", int'(max0), m_max);
            chk("min0", int'(min0), m_min);
            chk("max1", int'(max1), m_max);
            chk("min1", int'(min1), m_min);
        end
    endtask

    // Advance the model by one clock edge using the current inputs.
    task automatic model_step();
        bit acc = in_valid && !flush && (!m_hold || out_ready);
        if (m_hold && out_ready) m_hold = 1'b0;
        if (flush && !m_hold) win_q.delete();
        if (acc) begin
            win_q.push_back(int'(in_data));
            if (win_q.size() == WIN) begin
                m_total = 0;
                m_max   = 0;
                m_min   = 255;
                foreach (win_q[i]) begin
                    m_total += win_q[i];
                    if (win_q[i] > m_max) m_max = win_q[i];
                    if (win_q[i] < m_min) m_min = win_q[i];
                end
                win_q.delete();
                m_hold = 1'b1;
            end
        end
    endtask

    // One clock: drive, check at the falling edge, step model, pass the edge.
    task automatic cyc(input bit v, input int d, input bit f, input bit r);
        in_valid  = v;
        in_data   = 8'(d);
        flush     = f;
        out_ready = r;
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", int'(vld0) + int'(vld1), 0);
        chk("rst_sum", int'(sum0) + int'(sum1), 0);
        chk("rst_maxmin", int'(max0) + int'(min0) + int'(max1) + int'(min1), 0);
        chk("rst_ovf", int'(ovf0) + int'(ovf1), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        model_reset();
        #3;
        chk("init_valid", int'(vld0), 0);
        chk("init_sum", int'(sum0), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Asynchronous reset after three samples.
        for (int i = 0; i < 3; i++) cyc(1, 20 + i, 0, 1);
        reset_pulse();

        // Basic window 1..8, then 8x10 with no idle cycle.
        for (int i = 1; i <= 8; i++) cyc(1, i, 0, 1);
        chk("basic_valid", int'(vld0), 1);
        chk("basic_sum", int'(sum0), 36);
        chk("basic_max", int'(max0), 8);
        chk("basic_min", int'(min0), 1);
        chk("basic_ovf", int'(ovf0), 0);
        for (int i = 0; i < 8; i++) cyc(1, 10, 0, 1);
        chk("w10_sum", int'(sum0), 80);
        chk("w10_max", int'(max0), 10);
        chk("w10_min", int'(min0), 10);

        // Backpressure.
        begin
            int bp[8] = '{3, 9, 0, 7, 7, 1, 2, 4};
            foreach (bp[i]) cyc(1, bp[i], 0, 1);
        end
        chk("bp_sum", int'(sum0), 33);
        chk("bp_max", int'(max0), 9);
        chk("bp_min", int'(min0), 0);
        for (int i = 0; i < 5; i++) cyc(1, 77, 0, 0);
        cyc(1, 6, 0, 1);
        for (int i = 0; i < 7; i++) cyc(1, 1, 0, 1);
        chk("bp_next_sum", int'(sum0), 13);
        chk("bp_next_max", int'(max0), 6);

        // Flush wins over a simultaneous sample.
        for (int i = 0; i < 3; i++) cyc(1, 50, 0, 1);
        cyc(1, 99, 1, 1);
        for (int i = 0; i < 8; i++) cyc(1, 5, 0, 1);
        chk("flush_sum", int'(sum0), 40);
        chk("flush_max", int'(max0), 5);
        chk("flush_min", int'(min0), 5);

        // Saturation on the narrow instance.
        for (int i = 0; i < 8; i++) cyc(1, 255, 0, 1);
        chk("sat_sum1", int'(sum1), 1023);
        chk("sat_ovf1", int'(ovf1), 1);
        chk("sat_sum0", int'(sum0), 2040);
        chk("sat_max1", int'(max1), 255);
        for (int i = 0; i < 8; i++) cyc(1, 1, 0, 1);
        chk("unsat_sum1", int'(sum1), 8);
        chk("unsat_ovf1", int'(ovf1), 0);

        // Reset mid-window.
        for (int i = 0; i < 4; i++) cyc(1, 100, 0, 1);
        reset_pulse();
        for (int i = 0; i < 8; i++) cyc(1, 2, 0, 1);
        chk("rstmid_sum", int'(sum0), 16);
        chk("rstmid_max", int'(max0), 2);
        chk("rstmid_min", int'(min0), 2);

        // Reset mid-HOLD.
        for (int i = 0; i < 8; i++) cyc(1, 30, 0, 0);
        cyc(0, 0, 0, 0);
        reset_pulse();

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) reset_pulse();
            cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
                $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
